fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 53 +++++
 tb/tb_fetch_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: drives a registered PC to a combinational ROM.
// It captures one byte per fetch and holds it until the consumer accepts it.
module fetch_unit #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              ready,
   input  logic [DATA_W-1:0] rom_data,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instr,
   output logic [3:0]        opcode,
   output logic [3:0]        operand,
   output logic              instr_valid,
   output logic [1:0]        state
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] VALID = 2'd2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc    <= '0;
         instr <= '0;
         state <= IDLE;
      end else if (load) begin
         // A jump drops any in-flight or unconsumed byte; instr keeps its old value.
         pc    <= load_addr;
         state <= enable ? FETCH : IDLE;
      end else begin
         case (state)
            IDLE: if (enable) state <= FETCH;
            FETCH: begin
               instr <= rom_data;
               pc    <= pc + ADDR_W'(1);
               state <= VALID;
            end
            VALID: if (ready) state <= enable ? FETCH : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign instr_valid = (state == VALID);
   assign opcode      = instr[DATA_W-1 -: 4];
   assign operand     = instr[3:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic.
// All results are checked against a transaction-level model of the fetch rules.
module tb_fetch_unit;
   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset, enable, load, ready;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] rom_data;
   logic [AW-1:0] pc;
   logic [DW-1:0] instr;
   logic [3:0]    opcode, operand;
   logic          instr_valid;
   logic [1:0]    state;

   fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .load_addr(load_addr), .ready(ready), .rom_data(rom_data),
      .pc(pc), .instr(instr), .opcode(opcode), .operand(operand),
      .instr_valid(instr_valid), .state(state)
   );

   always #5 clk = ~clk;
   assign rom_data = pc[7:0] ^ 8'hA5;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a held byte, a pending fetch request, and a PC counter.
   int m_pc, m_instr;
   bit m_has, m_pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("pc", 32'(pc), 32'(m_pc));
      chk("instr", 32'(instr), 32'(m_instr));
      chk("opcode", 32'(opcode), 32'(m_instr / 16));
      chk("operand", 32'(operand), 32'(m_instr % 16));
      chk("valid", 32'(instr_valid), 32'(m_has));
      chk("state", 32'(state), m_has ? 32'd2 : (m_pend ? 32'd1 : 32'd0));
   endtask

   task automatic model_reset();
      m_pc = 0; m_instr = 0; m_has = 0; m_pend = 0;
   endtask

   task automatic model_edge(input bit en, input bit ld, input bit rdy, input int la);
      if (ld) begin
         m_pc = la % 4096; m_has = 0; m_pend = en;
      end else if (m_has) begin
         if (rdy) begin m_has = 0; m_pend = en; end
      end else if (m_pend) begin
         m_instr = (m_pc % 256) ^ 'hA5;
         m_pc = (m_pc + 1) % 4096;
         m_pend = 0; m_has = 1;
      end else if (en) begin
         m_pend = 1;
      end
   endtask

   // One clock: drive, edge, update model, check shortly after the edge.
   task automatic step(input bit en, input bit ld, input bit rdy, input int la);
      enable = en; load = ld; ready = rdy; load_addr = AW'(la);
      @(posedge clk);
      model_edge(en, ld, rdy, la);
      #1 check_all();
   endtask

   // Assert reset away from the edge, check immediately, release after one edge
   // during which load/enable are asserted to show reset dominance.
   task automatic async_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      model_reset();
      #1 check_all();
      enable = 1'b1; load = 1'b1; ready = 1'b1; load_addr = AW'(12'h123);
      @(posedge clk);
      #1 check_all();
      reset = 1'b0; load = 1'b0; enable = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 0; load = 0; ready = 0; load_addr = '0;
      model_reset();
      #1 check_all();
      @(posedge clk); #1 reset = 1'b0;

      // Sustained enable/ready: one byte every two cycles.
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 1, 0);
         step(1, 0, 1, 0);
         chk("seq_instr", 32'(instr), 32'(8'hA5 ^ k));
         chk("seq_pc", 32'(pc), 32'(k + 1));
      end

      // Back-pressure hold at pc=2.
      async_reset();
      for (int k = 0; k < 6; k++) step(1, 0, 1, 0);
      chk("hold_pre", 32'(instr), 32'hA7);
      for (int k = 0; k < 5; k++) step(k[0], 0, 0, 0);
      chk("hold_instr", 32'(instr), 32'hA7);
      chk("hold_pc", 32'(pc), 32'd3);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      chk("after_hold", 32'(instr), 32'hA6);

      // Jump to the top of memory and wrap.
      step(1, 1, 0, 'hFFF);
      chk("jmp_pc", 32'(pc), 32'hFFF);
      chk("jmp_state", 32'(state), 32'd1);
      step(1, 0, 1, 0);
      chk("wrap_instr", 32'(instr), 32'h5A);
      chk("wrap_pc", 32'(pc), 32'd0);
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      chk("wrap_next", 32'(instr), 32'hA5);

      // Load while an unconsumed byte is held.
      step(1, 1, 0, 'h010);
      chk("ld_valid", 32'(instr_valid), 32'd0);
      chk("ld_pc", 32'(pc), 32'h010);
      step(1, 0, 1, 0);
      chk("ld_instr", 32'(instr), 32'hB5);

      // Load onto the current pc, then async reset while fetching at pc=7.
      step(1, 1, 0, 'h011);
      step(1, 1, 0, 'h007);
      chk("f7_state", 32'(state), 32'd1);
      async_reset();
      chk("rst_pc", 32'(pc), 32'd0);

      // Consume then idle with enable low.
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
      for (int k = 0; k < 10; k++) step(0, 0, $urandom_range(0, 1), 0);
      chk("idle_pc", 32'(pc), 32'd1);
      chk("idle_state", 32'(state), 32'd0);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 39) == 0) async_reset();
         else step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 2) != 0, int'($urandom_range(0, 4095)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
